prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
// PURPOSE
//  Parametrised N-to-log2(N) priority encoder with a registered output stage and
//  valid/ready handshakes on input and output. Selectable fixed-priority or
//  round-robin mode. Successor to the combinational 8x3 encoder, for use as a
//  request arbiter/encoder in front of downstream pipelined consumers.
// PARAMETERS
//  N  8             number of request inputs (>=2, power of two)
//  W  $clog2(N)     width of encoded index output
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  mode       in   1  0 = fixed priority (highest index wins), 1 = round-robin
//  in_valid   in   1  req_i holds a request vector to encode
//  in_ready   out  1  block can accept req_i this cycle
//  req_i      in   N  request vector
//  out_valid  out  1  y/zero hold a valid result
//  out_ready  in   1  downstream accepts y/zero this cycle
//  y          out  W  encoded index of selected request bit
//  zero       out  1  1 = accepted vector was all zeros (y = 0)
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, y=0, zero=0, rr pointer ptr=0.
//  Handshake:
//   - in_ready = !out_valid || out_ready (combinational, single output register).
//   - Input accepted when in_valid && in_ready.
//   - Output consumed when out_valid && out_ready.
//  Latency: 1 cycle. A vector accepted at edge k is presented on y/zero with
//   out_valid=1 after edge k.
//  Throughput: with out_ready held at 1, one result per cycle.
//  Output hold: y/zero/out_valid must be stable while out_valid && !out_ready.
//  out_valid next state:
//   - 1 on accept.
//   - 0 on consume without accept.
//   - Otherwise held. Simultaneous consume+accept: new result loaded, out_valid stays 1.
//  Fixed mode (mode=0): y = index of highest set bit of req_i. ptr is not updated.
//  Round-robin mode (mode=1):
//   - Search downward starting at (ptr-1) mod N and wrapping N-1 -> 0.
//   - The first set bit found wins.
//   - On accept of a nonzero vector, ptr <= winning index.
//   - With ptr=0 the search starts at N-1, i.e. identical to fixed mode.
//  All-zero vector: y=0, zero=1, ptr unchanged. zero=0 for any nonzero vector.
//  mode is sampled only on accept; a mode change never alters a held result.
//  ptr is retained across mode switches; entering RR resumes from the stored ptr.
//  Reset mid-operation: pending result is discarded, out_valid=0 immediately,
//   in_ready=1 after reset deasserts.
//  Index arithmetic is modulo N (W-bit wrap); no X propagation from unused states.
// TESTING (N=8)
//  1. Fixed mode, out_ready=1:
//     req=00000001 -> y=0; 01011000 -> y=6; 10100000 -> y=7; 10000100 -> y=7;
//     each result valid 1 cycle after accept.
//  2. Zero input: req=00000000 -> y=0, zero=1, out_valid=1; ptr unchanged.
//  3. Round-robin, ptr=0, req=11100000 held for 4 accepts -> y=7,6,5,7.
//     Then req=00000101 -> y=2, then y=0.
//  4. Backpressure: out_ready=0 after one accept (y=6) -> in_ready=0;
//     y stays 6 for 5 cycles; second vector 00000010 not taken until out_ready=1,
//     then y=1 the next cycle.
//  5. Streaming: in_valid=out_ready=1 for 8 distinct vectors -> 8 results on
//     8 consecutive cycles, in order, no bubbles.
//  6. Assert rst mid-stream with out_valid=1 (RR, ptr=5) -> out_valid=0, y=0 at once.
//     After release, req=11100000 in RR -> y=7 (ptr back to 0).

Source files
------------

// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle for prio_encoder_rr.
// master drives requests and accepts results; slave is the encoder.
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zero;

  modport master (
    output mode,
    output in_valid,
    input  in_ready,
    output req_i,
    input  out_valid,
    output out_ready,
    input  y,
    input  zero
  );

  modport slave (
    input  mode,
    input  in_valid,
    output in_ready,
    input  req_i,
    output out_valid,
    input  out_ready,
    output y,
    output zero
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed or round-robin.
// One output register; input stalls only while a result is held.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  prio_encoder_rr_if.slave bus
);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] idx;
  logic [W-1:0] win;
  logic         hit;
  logic         accept;
  logic         consume;
  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic         zero_q;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign consume = out_valid_q && bus.out_ready;

  // Fixed mode is a downward search from N-1; RR starts just below ptr.
  always_comb begin
    start = bus.mode ? ptr - 1'b1 : {W{1'b1}};
    idx   = '0;
    win   = '0;
    hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start - W'(i);
      if (!hit && bus.req_i[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      ptr         <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        y_q         <= win;
        zero_q      <= !hit;
        if (bus.mode && hit) begin
          ptr <= win;
        end
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: directed cases plus random traffic.
// Expected results are queued at accept and checked by a separate monitor.
module tb_prio_encoder_rr;
  localparam int N = 8;

  typedef struct {
    int y;
    bit z;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   mptr;
  bit   rand_bp;
  exp_t q[$];

  prio_encoder_rr_if #(.N(N)) bus ();

  prio_encoder_rr #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk indices downward from the start point, first set bit wins.
  function automatic int ref_enc(input logic [N-1:0] r, input bit m, input int p);
    int base;
    int c;
    base = m ? p : 0;
    for (int k = 1; k <= N; k++) begin
      c = (base - k + 2 * N) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Entered and left at posedge+2; decision made at posedge+7.
  task automatic send(input logic [N-1:0] r, input bit m,
                      input int ey, output int waits);
    int   w;
    exp_t e;
    bus.req_i    = r;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    waits = 0;
    forever begin
      #5;
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #2;
      if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end
    w = ref_enc(r, m, mptr);
    if (w < 0) begin
      e.y = 0;
      e.z = 1'b1;
    end else begin
      e.y = w;
      e.z = 1'b0;
      if (m) mptr = w;
    end
    if (ey >= 0) e.y = ey;
    q.push_back(e);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: any pending expectation means the register must be showing it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
        if (bus.out_valid && q.size() != 0) begin
          chk("y", int'(bus.y), q[0].y);
          chk("zero", int'(bus.zero), int'(q[0].z));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    int nb;
    logic [N-1:0] v;
    logic [N-1:0] stream [8];
    n_tests = 0;
    n_fail = 0;
    mptr = 0;
    rand_bp = 1'b0;
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.req_i = '0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_zero", int'(bus.zero), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    idle(1);

    send(8'b0000_0001, 1'b0, 0, w);
    send(8'b0101_1000, 1'b0, 6, w);
    send(8'b1010_0000, 1'b0, 7, w);
    send(8'b1000_0100, 1'b0, 7, w);
    idle(2);

    send(8'b0000_0000, 1'b0, 0, w);
    idle(2);

    send(8'b1110_0000, 1'b1, 7, w);
    send(8'b1110_0000, 1'b1, 6, w);
    send(8'b1110_0000, 1'b1, 5, w);
    send(8'b1110_0000, 1'b1, 7, w);
    send(8'b0000_0101, 1'b1, 2, w);
    send(8'b0000_0101, 1'b1, 0, w);
    idle(2);

    bus.out_ready = 1'b0;
    send(8'b0101_1000, 1'b0, 6, w);
    bus.req_i = 8'b0000_0010;
    bus.in_valid = 1'b1;
    repeat (5) begin
      #5;
      chk("bp_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #2;
    end
    bus.out_ready = 1'b1;
    send(8'b0000_0010, 1'b0, 1, w);
    chk("bp_release_wait", w, 0);
    idle(2);

    nb = 0;
    for (int i = 0; i < 8; i++) stream[i] = 8'(1 << i) | 8'(i * 37);
    for (int i = 0; i < 8; i++) begin
      send(stream[i], 1'b1, -1, w);
      nb += w;
    end
    chk("stream_bubbles", nb, 0);
    idle(2);

    // Park the pointer at 5, hold the result, then reset under it.
    mptr = 0;
    send(8'b1110_0000, 1'b1, -1, w);
    send(8'b1110_0000, 1'b1, -1, w);
    send(8'b1110_0000, 1'b1, -1, w);
    idle(2);
    bus.out_ready = 1'b0;
    send(8'b0010_0000, 1'b1, 5, w);
    idle(1);
    #1;
    rst = 1'b1;
    q.delete();
    mptr = 0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_y", int'(bus.y), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    send(8'b1110_0000, 1'b1, 7, w);
    idle(2);

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      send(v, 1'($urandom_range(0, 1)), -1, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;

    w = 0;
    while (q.size() != 0 && w < 20) begin
      idle(1);
      w++;
    end
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
